counter_interval_ctrl: RTL and testbench

Sequencing controller around a loadable up-counter. It takes a start value, a limit and a mode over a valid/ready configuration handshake. It then runs, pauses, aborts and terminates the count, either one-shot or auto-reloading. It is the control layer that owns the counter's reset, load and increment decisions, and it reports terminal-count events to downstream logic.

---
 rtl/counter_interval_ctrl.sv | 156 +++++++++++++++
 tb/tb_counter_interval_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_interval_ctrl.sv
// counter_interval_ctrl: sequencing controller around a loadable up-counter.
// Holds a start/limit/reload configuration and decides when the counter is
// loaded, incremented, held or reloaded. It also reports terminal-count events
// as a one-cycle tick and as a saturating event count.
//
// Handshake: a configuration transfers on a rising edge where
// cfg_valid && cfg_ready. cfg_ready is decoded from the state register and is
// high only in IDLE or DONE. cfg_valid offered while busy is simply not taken.
module counter_interval_ctrl #(
    parameter int WIDTH = 8,
    parameter int TC_W  = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_reload,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [TC_W-1:0]  tc_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [TC_W-1:0] TC_MAX = '1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              tick_q, tick_d;
    logic [TC_W-1:0]   tc_q, tc_d;
    logic [WIDTH-1:0]  start_reg_q, start_reg_d;
    logic [WIDTH-1:0]  limit_reg_q, limit_reg_d;
    logic              reload_reg_q, reload_reg_d;
    logic              loaded_q, loaded_d;

    logic              xfer;
    logic              terminal;

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done      = (state_q == ST_DONE);
    assign count     = count_q;
    assign tick      = tick_q;
    assign tc_count  = tc_q;

    assign xfer     = cfg_valid && cfg_ready;
    assign terminal = (count_q == limit_reg_q);

    // Next-state and counter decisions; a config transfer overrides everything else.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        tick_d       = 1'b0;
        tc_d         = tc_q;
        start_reg_d  = start_reg_q;
        limit_reg_d  = limit_reg_q;
        reload_reg_d = reload_reg_q;
        loaded_d     = loaded_q;

        if (xfer) begin
            start_reg_d  = cfg_start;
            limit_reg_d  = cfg_limit;
            reload_reg_d = cfg_reload;
            loaded_d     = 1'b1;
            count_d      = cfg_start;
            tc_d         = '0;
            state_d      = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Entering RUN leaves count alone, so the first increment is one edge later.
                    if (start && loaded_q) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_d = ST_IDLE;
                        count_d = start_reg_q;
                    end else if (terminal) begin
                        tick_d = 1'b1;
                        if (tc_q != TC_MAX) begin
                            tc_d = tc_q + TC_W'(1);
                        end
                        if (reload_reg_q) begin
                            count_d = start_reg_q;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                ST_PAUSE: begin
                    // Terminal is not evaluated while paused; resuming costs one edge.
                    if (abort) begin
                        state_d = ST_IDLE;
                        count_d = start_reg_q;
                    end else if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        state_d = ST_IDLE;
                        count_d = start_reg_q;
                    end else if (start) begin
                        state_d = ST_RUN;
                        count_d = start_reg_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            tick_q       <= 1'b0;
            tc_q         <= '0;
            start_reg_q  <= '0;
            limit_reg_q  <= '0;
            reload_reg_q <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            tick_q       <= tick_d;
            tc_q         <= tc_d;
            start_reg_q  <= start_reg_d;
            limit_reg_q  <= limit_reg_d;
            reload_reg_q <= reload_reg_d;
            loaded_q     <= loaded_d;
        end
    end

endmodule

// File: tb/tb_counter_interval_ctrl.sv
// Testbench for counter_interval_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_counter_interval_ctrl;

    logic       clock;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_start;
    logic [7:0] cfg_limit;
    logic       cfg_reload;
    logic       start;
    logic       pause;
    logic       abort;
    logic [7:0] count;
    logic       busy;
    logic       tick;
    logic       done;
    logic [7:0] tc_count;

    int n_checks = 0;
    int n_err    = 0;

    counter_interval_ctrl #(.WIDTH(8), .TC_W(8)) dut (
        .clock     (clock),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_start (cfg_start),
        .cfg_limit (cfg_limit),
        .cfg_reload(cfg_reload),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .count     (count),
        .busy      (busy),
        .tick      (tick),
        .done      (done),
        .tc_count  (tc_count)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Behavioural model: phase as an integer, values as plain integers
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_PAUSE = 2;
    localparam int P_DONE  = 3;

    int m_phase, m_count, m_tick, m_tc, m_s, m_l, m_rl, m_loaded;

    task automatic model_update(input int r, cv, cs, cl, crl, st, ps, ab);
        int nt;
        if (r != 0) begin
            m_phase = P_IDLE; m_count = 0; m_tick = 0; m_tc = 0;
            m_s = 0; m_l = 0; m_rl = 0; m_loaded = 0;
            return;
        end
        nt = 0;
        if (cv != 0 && (m_phase == P_IDLE || m_phase == P_DONE)) begin
            m_s = cs; m_l = cl; m_rl = crl; m_loaded = 1;
            m_count = cs; m_tc = 0; m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            if (st != 0 && m_loaded != 0) m_phase = P_RUN;
        end else if (m_phase == P_RUN) begin
            if (ab != 0) begin
                m_phase = P_IDLE; m_count = m_s;
            end else if (m_count == m_l) begin
                nt = 1;
                if (m_tc < 255) m_tc = m_tc + 1;
                if (m_rl != 0) m_count = m_s;
                else m_phase = P_DONE;
            end else if (ps != 0) begin
                m_phase = P_PAUSE;
            end else begin
                m_count = (m_count + 1) % 256;
            end
        end else if (m_phase == P_PAUSE) begin
            if (ab != 0) begin
                m_phase = P_IDLE; m_count = m_s;
            end else if (ps == 0) begin
                m_phase = P_RUN;
            end
        end else begin
            if (ab != 0) begin
                m_phase = P_IDLE; m_count = m_s;
            end else if (st != 0) begin
                m_phase = P_RUN; m_count = m_s;
            end
        end
        m_tick = nt;
    endtask

    function automatic logic [19:0] model_pack();
        logic [7:0] c8, t8;
        logic       b, d, rd;
        c8 = m_count[7:0];
        t8 = m_tc[7:0];
        b  = (m_phase == P_RUN) || (m_phase == P_PAUSE);
        d  = (m_phase == P_DONE);
        rd = (m_phase == P_IDLE) || (m_phase == P_DONE);
        return {c8, b, (m_tick != 0), d, t8, rd};
    endfunction

    // Scoreboard
    logic [19:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_sb();
        logic [19:0] e;
        e = exp_q.pop_front();
        check("sb_count", int'(count), int'(e[19:12]));
        check("sb_busy", int'(busy), int'(e[11]));
        check("sb_tick", int'(tick), int'(e[10]));
        check("sb_done", int'(done), int'(e[9]));
        check("sb_tc", int'(tc_count), int'(e[8:1]));
        check("sb_ready", int'(cfg_ready), int'(e[0]));
    endtask

    // Driver tasks
    task automatic drive_edge(input int r, cv, cs, cl, crl, st, ps, ab);
        rst        = r[0];
        cfg_valid  = cv[0];
        cfg_start  = cs[7:0];
        cfg_limit  = cl[7:0];
        cfg_reload = crl[0];
        start      = st[0];
        pause      = ps[0];
        abort      = ab[0];
        @(posedge clock);
        model_update(r, cv, cs, cl, crl, st, ps, ab);
        #1;
    endtask

    task automatic step(input int r, cv, cs, cl, crl, st, ps, ab);
        drive_edge(r, cv, cs, cl, crl, st, ps, ab);
        exp_q.push_back(model_pack());
        compare_sb();
    endtask

    task automatic do_rst();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_cfg(input int s, l, rl);
        step(0, 1, s, l, rl, 0, 0, 0);
    endtask

    task automatic do_ctl(input int st, ps, ab);
        step(0, 0, 0, 0, 0, st, ps, ab);
    endtask

    // Directed vector table
    typedef struct {
        int r, cv, cs, cl, crl, st, ps, ab;
        int e_count, e_busy, e_tick, e_done, e_tc, e_ready;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    initial begin
        int last_k, ticks;

        rst = 1'b1; cfg_valid = 1'b0; cfg_start = '0; cfg_limit = '0;
        cfg_reload = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;

        //            r cv cs cl crl st ps ab   cnt bsy tck dn tc rdy
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1};
        vecs[1]  = '{0, 1, 3, 6, 0, 0, 0, 0,    3, 0, 0, 0, 0, 1};
        vecs[2]  = '{0, 0, 0, 0, 0, 1, 0, 0,    3, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0,    4, 1, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,    5, 1, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,    6, 1, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,    6, 0, 1, 1, 1, 1};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,    6, 0, 0, 1, 1, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 1,    3, 0, 0, 0, 1, 1};
        vecs[9]  = '{1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 1, 0, 0,    0, 0, 0, 0, 0, 1};
        vecs[11] = '{0, 1, 5, 7, 1, 1, 0, 0,    5, 0, 0, 0, 0, 1};
        vecs[12] = '{0, 0, 0, 0, 0, 1, 0, 0,    5, 1, 0, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0,    6, 1, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0,    7, 1, 0, 0, 0, 0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0,    5, 1, 1, 0, 1, 0};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0,    6, 1, 0, 0, 1, 0};
        vecs[17] = '{0, 1, 9, 9, 0, 0, 0, 0,    7, 1, 0, 0, 1, 0};
        vecs[18] = '{0, 0, 0, 0, 0, 0, 1, 0,    5, 1, 1, 0, 2, 0};
        vecs[19] = '{0, 0, 0, 0, 0, 0, 1, 0,    5, 1, 0, 0, 2, 0};
        vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0,    5, 1, 0, 0, 2, 0};
        vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0,    6, 1, 0, 0, 2, 0};
        vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 1,    5, 0, 0, 0, 2, 1};

        for (int i = 0; i < NV; i++) begin
            drive_edge(vecs[i].r, vecs[i].cv, vecs[i].cs, vecs[i].cl,
                       vecs[i].crl, vecs[i].st, vecs[i].ps, vecs[i].ab);
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].e_count);
            check($sformatf("vec%0d_busy", i), int'(busy), vecs[i].e_busy);
            check($sformatf("vec%0d_tick", i), int'(tick), vecs[i].e_tick);
            check($sformatf("vec%0d_done", i), int'(done), vecs[i].e_done);
            check($sformatf("vec%0d_tc", i), int'(tc_count), vecs[i].e_tc);
            check($sformatf("vec%0d_ready", i), int'(cfg_ready), vecs[i].e_ready);
        end

        // Reload across the wrap: 250..255,0,1,2 gives a 9-cycle period
        do_rst();
        do_cfg(250, 2, 1);
        do_ctl(1, 0, 0);
        check("wrap_first_count", int'(count), 250);
        last_k = -1;
        ticks  = 0;
        for (int k = 1; k <= 30; k++) begin
            do_ctl(1, 0, 0);
            if (tick) begin
                if (last_k >= 0) check("reload_period", k - last_k, 9);
                last_k = k;
                ticks++;
            end
        end
        check("reload_ticks", ticks, 3);
        check("reload_tc", int'(tc_count), 3);

        // Pause holds the count and resuming does not increment
        do_rst();
        do_cfg(0, 10, 0);
        do_ctl(1, 0, 0);
        for (int i = 0; i < 20 && count != 8'd5; i++) do_ctl(0, 0, 0);
        check("pause_reach5", int'(count), 5);
        for (int i = 0; i < 4; i++) begin
            do_ctl(0, 1, 0);
            check("pause_hold_count", int'(count), 5);
            check("pause_busy", int'(busy), 1);
            check("pause_done", int'(done), 0);
        end
        do_ctl(0, 0, 0);
        check("resume_no_inc", int'(count), 5);
        for (int i = 0; i < 20 && !done; i++) do_ctl(0, 0, 0);
        check("oneshot_done", int'(done), 1);
        check("oneshot_count", int'(count), 10);
        check("oneshot_tc", int'(tc_count), 1);

        // Abort in RUN and in PAUSE keeps tc_count; cfg_valid while busy is ignored
        do_rst();
        do_cfg(2, 9, 1);
        do_ctl(1, 0, 0);
        for (int i = 0; i < 20 && tc_count != 8'd1; i++) do_ctl(0, 0, 0);
        check("abort_tc_before", int'(tc_count), 1);
        for (int i = 0; i < 20 && count != 8'd7; i++) begin
            step(0, 1, 100, 100, 0, 0, 0, 0);
            check("busy_cfg_ready", int'(cfg_ready), 0);
        end
        check("abort_reach7", int'(count), 7);
        do_ctl(0, 0, 1);
        check("abort_run_count", int'(count), 2);
        check("abort_run_busy", int'(busy), 0);
        check("abort_run_tc", int'(tc_count), 1);
        do_ctl(1, 0, 0);
        do_ctl(0, 1, 0);
        check("abort_pause_entered", int'(busy), 1);
        do_ctl(0, 1, 1);
        check("abort_pause_count", int'(count), 2);
        check("abort_pause_busy", int'(busy), 0);
        check("abort_pause_tc", int'(tc_count), 1);

        // Reset mid-run clears everything including the loaded config
        do_rst();
        do_cfg(0, 100, 0);
        do_ctl(1, 0, 0);
        for (int i = 0; i < 60 && count != 8'd40; i++) do_ctl(0, 0, 0);
        check("rst_reach40", int'(count), 40);
        do_rst();
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_tc", int'(tc_count), 0);
        do_ctl(1, 0, 0);
        check("rst_start_ignored_count", int'(count), 0);
        check("rst_start_ignored_busy", int'(busy), 0);

        // start == limit in reload mode ticks every cycle; tc_count saturates
        do_rst();
        do_cfg(5, 5, 1);
        do_ctl(1, 0, 0);
        ticks = 0;
        for (int i = 0; i < 300; i++) begin
            do_ctl(0, 0, 0);
            if (tick) ticks++;
        end
        check("sat_ticks", ticks, 300);
        check("sat_tc", int'(tc_count), 255);

        // Randomized traffic against the model
        do_rst();
        for (int i = 0; i < 2500; i++) begin
            int r, cv, cs, cl, crl, st, ps, ab;
            r   = (($urandom_range(0, 199)) == 0) ? 1 : 0;
            cv  = (($urandom_range(0, 7)) == 0) ? 1 : 0;
            cs  = int'($urandom_range(0, 255));
            cl  = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(0, 255))
                                               : (cs + int'($urandom_range(0, 12))) % 256;
            crl = int'($urandom_range(0, 1));
            st  = (($urandom_range(0, 2)) == 0) ? 1 : 0;
            ps  = (($urandom_range(0, 3)) == 0) ? 1 : 0;
            ab  = (($urandom_range(0, 19)) == 0) ? 1 : 0;
            step(r, cv, cs, cl, crl, st, ps, ab);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
